fifo_readout_ctrl: RTL

Sequences readout of the on-chip event FIFO for the SPI host. It generates the level interrupt from the programmable assert/deassert thresholds with hysteresis. It executes host-requested read bursts, issuing `fifo_rd_en` and handing words to the SPI stream path over a valid/ready handshake. It also owns the timed FIFO flush (`fifo_rst_n` pulse). It sits between the regfile outputs (`irq_assert_thresh`, `irq_deassert_thresh`, burst/flush strobes) and the event FIFO.

---
 rtl/fifo_readout_ctrl_pkg.sv | 14 +
 rtl/fifo_readout_ctrl_if.sv | 15 +
 rtl/fifo_readout_ctrl_irq_hysteresis.sv | 33 +++
 rtl/fifo_readout_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fifo_readout_ctrl_pkg.sv
// Shared types and default widths for the event FIFO readout controller.
package fifo_readout_ctrl_pkg;

   localparam int FIFO_AWIDTH = 10;
   localparam int EVT_DWIDTH  = 16;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      FLUSH
   } readout_state_e;

endpackage

// File: rtl/fifo_readout_ctrl_if.sv
// Valid/ready word stream from the readout controller to the SPI stream path.
interface fifo_readout_ctrl_if
   import fifo_readout_ctrl_pkg::*;
#(
   parameter int DWIDTH = EVT_DWIDTH
);

   logic              out_valid;
   logic [DWIDTH-1:0] out_data;
   logic              out_ready;

   modport master (output out_valid, output out_data, input  out_ready);
   modport slave  (input  out_valid, input  out_data, output out_ready);

endinterface

// File: rtl/fifo_readout_ctrl_irq_hysteresis.sv
// Level monitor: set/clear register driven by two thresholds; set wins on overlap.
module irq_hysteresis
   import fifo_readout_ctrl_pkg::*;
#(
   parameter int WIDTH = FIFO_AWIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_level,
   input  logic [WIDTH-1:0] i_set_thresh,
   input  logic [WIDTH-1:0] i_clr_thresh,
   output logic             o_irq
);

   logic r_irq;

   // A zero set threshold disables the monitor entirely.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_irq <= 1'b0;
      end else if (i_set_thresh == '0) begin
         r_irq <= 1'b0;
      end else if (i_level >= i_set_thresh) begin
         r_irq <= 1'b1;
      end else if (i_level <= i_clr_thresh) begin
         r_irq <= 1'b0;
      end
   end

   assign o_irq = r_irq;

endmodule

// File: rtl/fifo_readout_ctrl.sv
// Event FIFO readout sequencer: host read bursts, timed FIFO flush and level irq.
module fifo_readout_ctrl
   import fifo_readout_ctrl_pkg::*;
#(
   parameter int AWIDTH     = FIFO_AWIDTH,
   parameter int DWIDTH     = EVT_DWIDTH,
   parameter int RST_CYCLES = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [AWIDTH-1:0]   i_irq_assert_thresh,
   input  logic [AWIDTH-1:0]   i_irq_deassert_thresh,
   input  logic [AWIDTH-1:0]   i_fifo_numel,
   input  logic                i_burst_start,
   input  logic [AWIDTH-1:0]   i_burst_len,
   input  logic                i_flush_req,
   output logic                o_fifo_rd_en,
   input  logic [DWIDTH-1:0]   i_fifo_rdata,
   output logic                o_fifo_rst_n,
   fifo_readout_ctrl_if.master o_stream,
   output logic                o_busy,
   output logic                o_burst_done,
   output logic [AWIDTH-1:0]   o_words_read,
   output logic                o_irq
);

   localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   readout_state_e    r_state,       w_state_nxt;
   logic              r_pending,     w_pending_nxt;
   logic [AWIDTH-1:0] r_remaining,   w_remaining_nxt;
   logic              r_out_valid,   w_out_valid_nxt;
   logic [DWIDTH-1:0] r_out_data,    w_out_data_nxt;
   logic [AWIDTH-1:0] r_words_read,  w_words_read_nxt;
   logic              r_fifo_rd_en,  w_fifo_rd_en_nxt;
   logic              r_fifo_rst_n,  w_fifo_rst_n_nxt;
   logic              r_burst_done,  w_burst_done_nxt;
   logic              r_busy;
   logic [CNT_W-1:0]  r_rst_cnt,     w_rst_cnt_nxt;
   logic              w_xfer;
   logic              w_slot_free;
   logic              w_irq_clr;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_pending    <= 1'b0;
         r_remaining  <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_words_read <= '0;
         r_fifo_rd_en <= 1'b0;
         r_fifo_rst_n <= 1'b0;
         r_burst_done <= 1'b0;
         r_busy       <= 1'b0;
         r_rst_cnt    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pending    <= w_pending_nxt;
         r_remaining  <= w_remaining_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_out_data   <= w_out_data_nxt;
         r_words_read <= w_words_read_nxt;
         r_fifo_rd_en <= w_fifo_rd_en_nxt;
         r_fifo_rst_n <= w_fifo_rst_n_nxt;
         r_burst_done <= w_burst_done_nxt;
         r_busy       <= (w_state_nxt != IDLE);
         r_rst_cnt    <= w_rst_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pending_nxt    = r_pending;
      w_remaining_nxt  = r_remaining;
      w_out_valid_nxt  = r_out_valid;
      w_out_data_nxt   = r_out_data;
      w_words_read_nxt = r_words_read;
      w_fifo_rd_en_nxt = 1'b0;
      w_fifo_rst_n_nxt = 1'b1;
      w_burst_done_nxt = 1'b0;
      w_rst_cnt_nxt    = r_rst_cnt;

      w_xfer      = r_out_valid && o_stream.out_ready;
      // The output slot counts as free when the word in it is handed over this
      // cycle, which is what allows a read every second cycle.
      w_slot_free = !r_pending && (!r_out_valid || o_stream.out_ready);

      if (w_xfer) begin
         w_out_valid_nxt  = 1'b0;
         w_words_read_nxt = r_words_read + AWIDTH'(1);
      end
      if (r_pending) begin
         w_out_data_nxt  = i_fifo_rdata;
         w_out_valid_nxt = 1'b1;
         w_pending_nxt   = 1'b0;
      end

      case (r_state)
         IDLE: begin
            if (i_burst_start) begin
               w_words_read_nxt = '0;
               if (i_burst_len == '0) begin
                  w_state_nxt = DRAIN;
               end else begin
                  w_state_nxt = READ;
                  if (i_fifo_numel != '0) begin
                     w_fifo_rd_en_nxt = 1'b1;
                     w_pending_nxt    = 1'b1;
                     w_remaining_nxt  = i_burst_len - AWIDTH'(1);
                  end else begin
                     w_remaining_nxt  = i_burst_len;
                  end
               end
            end
         end
         READ: begin
            if (r_remaining != '0 && i_fifo_numel != '0 && w_slot_free) begin
               w_fifo_rd_en_nxt = 1'b1;
               w_pending_nxt    = 1'b1;
               w_remaining_nxt  = r_remaining - AWIDTH'(1);
            end else if (r_remaining == '0 || (i_fifo_numel == '0 && !r_pending)) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_slot_free) begin
               w_burst_done_nxt = 1'b1;
               w_state_nxt      = IDLE;
            end
         end
         FLUSH: begin
            if (r_rst_cnt == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_fifo_rst_n_nxt = 1'b0;
               w_rst_cnt_nxt    = r_rst_cnt - CNT_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // Flush overrides everything, including a same-cycle burst start.
      if (i_flush_req) begin
         w_state_nxt      = FLUSH;
         w_pending_nxt    = 1'b0;
         w_out_valid_nxt  = 1'b0;
         w_fifo_rd_en_nxt = 1'b0;
         w_burst_done_nxt = 1'b0;
         w_fifo_rst_n_nxt = 1'b0;
         w_rst_cnt_nxt    = CNT_W'(RST_CYCLES - 1);
      end

      w_irq_clr = (w_state_nxt == FLUSH);
   end

   irq_hysteresis #(
      .WIDTH (AWIDTH)
   ) u_irq (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clr        (w_irq_clr),
      .i_level      (i_fifo_numel),
      .i_set_thresh (i_irq_assert_thresh),
      .i_clr_thresh (i_irq_deassert_thresh),
      .o_irq        (o_irq)
   );

   assign o_fifo_rd_en       = r_fifo_rd_en;
   assign o_fifo_rst_n       = r_fifo_rst_n;
   assign o_stream.out_valid = r_out_valid;
   assign o_stream.out_data  = r_out_data;
   assign o_busy             = r_busy;
   assign o_burst_done       = r_burst_done;
   assign o_words_read       = r_words_read;

endmodule
